// File: rtl/cordic_atan_prerotator.sv
// Quadrant pre-rotation ahead of a CORDIC atan core: folds (x,y) into the
// right half-plane, records the angle offset, and buffers through a 2-entry skid.
module cordic_atan_prerotator #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [DATA_WIDTH-1:0]  s_x,
    input  logic signed [DATA_WIDTH-1:0]  s_y,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic signed [DATA_WIDTH:0]    m_x,
    output logic signed [DATA_WIDTH:0]    m_y,
    output logic signed [ANGLE_WIDTH-1:0] m_angle,
    output logic                          m_zero
);

    localparam int XW = DATA_WIDTH + 1;

    localparam logic signed [ANGLE_WIDTH-1:0] QUARTER     = {2'b01, {(ANGLE_WIDTH-2){1'b0}}};
    localparam logic signed [ANGLE_WIDTH-1:0] NEG_QUARTER = {2'b11, {(ANGLE_WIDTH-2){1'b0}}};

    typedef struct packed {
        logic signed [XW-1:0]          x;
        logic signed [XW-1:0]          y;
        logic signed [ANGLE_WIDTH-1:0] angle;
        logic                          zero;
    } word_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    word_t  main_q, main_d;
    word_t  skid_q, skid_d;
    logic   s_ready_q, s_ready_d;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] y_ext;
    word_t                in_word;
    logic                 accept;
    logic                 out_xfer;

    // Widen before negating so the most negative input maps without wrap.
    always_comb begin
        x_ext         = {s_x[DATA_WIDTH-1], s_x};
        y_ext         = {s_y[DATA_WIDTH-1], s_y};
        in_word       = '0;
        in_word.zero  = (s_x == '0) && (s_y == '0);
        if (!x_ext[XW-1]) begin
            in_word.x     = x_ext;
            in_word.y     = y_ext;
            in_word.angle = '0;
        end else if (!y_ext[XW-1]) begin
            in_word.x     = y_ext;
            in_word.y     = -x_ext;
            in_word.angle = QUARTER;
        end else begin
            in_word.x     = -y_ext;
            in_word.y     = x_ext;
            in_word.angle = NEG_QUARTER;
        end
    end

    assign accept   = s_valid && s_ready_q;
    assign out_xfer = (state_q != ST_EMPTY) && m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({accept, out_xfer})
                    2'b10: begin
                        skid_d  = in_word;
                        state_d = ST_FULL;
                    end
                    2'b11: begin
                        main_d  = in_word;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    default: begin
                        state_d = ST_ONE;
                    end
                endcase
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Registered ready: it only ever depends on the state being entered.
        s_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = (state_q != ST_EMPTY);
    assign m_x     = main_q.x;
    assign m_y     = main_q.y;
    assign m_angle = main_q.angle;
    assign m_zero  = main_q.zero;

endmodule

// File: tb/tb_cordic_atan_prerotator.sv
// Self-checking bench for cordic_atan_prerotator: directed corner words,
// backpressure, random traffic against a scoreboard, and mid-stream reset.
`timescale 1ns/1ps
module tb_cordic_atan_prerotator;

    localparam int     DW = 16;
    localparam int     AW = 16;
    localparam longint Q  = longint'(1) << (AW - 2);

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_x;
    logic signed [DW-1:0] s_y;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW:0]   m_x;
    logic signed [DW:0]   m_y;
    logic signed [AW-1:0] m_angle;
    logic                 m_zero;

    always #5 clk = ~clk;

    cordic_atan_prerotator #(
        .DATA_WIDTH  (DW),
        .ANGLE_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .s_y     (s_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_angle (m_angle),
        .m_zero  (m_zero)
    );

    typedef struct {
        longint x;
        longint y;
        longint angle;
        longint zero;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input longint x, input longint y);
        exp_t e;
        e.zero = (x == 0 && y == 0) ? 1 : 0;
        if (x >= 0) begin
            e.x = x;  e.y = y;  e.angle = 0;
        end else if (y >= 0) begin
            e.x = y;  e.y = -x; e.angle = Q;
        end else begin
            e.x = -y; e.y = x;  e.angle = -Q;
        end
        return e;
    endfunction

    function automatic logic signed [DW-1:0] rand_coord();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            2:       return 16'sd0;
            3:       return -16'sd1;
            default: return DW'($urandom);
        endcase
    endfunction

    // Monitor: scoreboard push/pop and hold-stability, sampled on the falling edge.
    initial begin
        logic                 hold_v;
        logic signed [DW:0]   hx, hy;
        logic signed [AW-1:0] ha;
        logic                 hz;
        exp_t                 e;
        hold_v = 1'b0;
        hx = '0; hy = '0; ha = '0; hz = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold_v = 1'b0;
            end else begin
                if (s_valid && s_ready) sb_q.push_back(model(s_x, s_y));
                if (hold_v) begin
                    check_val("hold_valid", m_valid, 1);
                    check_val("hold_x", m_x, hx);
                    check_val("hold_y", m_y, hy);
                    check_val("hold_angle", m_angle, ha);
                    check_val("hold_zero", m_zero, hz);
                end
                if (m_valid && m_ready) begin
                    $display("xfer x=%0d y=%0d angle=%0d zero=%0d", m_x, m_y, m_angle, m_zero);
                    check_val("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check_val("sb_x", m_x, e.x);
                        check_val("sb_y", m_y, e.y);
                        check_val("sb_angle", m_angle, e.angle);
                        check_val("sb_zero", m_zero, e.zero);
                    end
                end
                hold_v = m_valid && !m_ready;
                hx = m_x; hy = m_y; ha = m_angle; hz = m_zero;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; leaves the word accepted, checked, and drained.
    task automatic apply_word(input string tag, input longint x, input longint y,
                              input longint ex, input longint ey, input longint ea,
                              input longint ez);
        m_ready = 1'b1;
        s_x     = DW'(x);
        s_y     = DW'(y);
        s_valid = 1'b1;
        @(negedge clk);
        check_val({tag, "_ready"}, s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_valid"}, m_valid, 1);
        check_val({tag, "_x"}, m_x, ex);
        check_val({tag, "_y"}, m_y, ey);
        check_val({tag, "_angle"}, m_angle, ea);
        check_val({tag, "_zero"}, m_zero, ez);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;
        int cycles;
        int waited;
        resetn  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_x     = '0;
        s_y     = '0;

        repeat (3) @(negedge clk);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_m_x", m_x, 0);
        check_val("rst_m_y", m_y, 0);
        check_val("rst_m_angle", m_angle, 0);
        check_val("rst_m_zero", m_zero, 0);
        resetn = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", s_ready, 1);
        check_val("empty_after_reset", m_valid, 0);
        @(posedge clk); #1;

        apply_word("neg_x_pos_y", -100, 50, 50, 100, Q, 0);
        apply_word("min_x_neg_y", -32768, -1, 1, -32768, -Q, 0);
        apply_word("min_x_zero_y", -32768, 0, 0, 32768, Q, 0);
        apply_word("zero_vec", 0, 0, 0, 0, 0, 1);
        apply_word("pos_x", 5, -7, 5, -7, 0, 0);

        // Backpressure: A, B fill the buffer, C waits until A leaves.
        m_ready = 1'b0;
        s_valid = 1'b1; s_x = 3; s_y = 4;
        @(posedge clk); #1;
        s_x = -5; s_y = 6;
        @(negedge clk);
        check_val("bp_a_valid", m_valid, 1);
        check_val("bp_a_x", m_x, 3);
        check_val("bp_one_ready", s_ready, 1);
        @(posedge clk); #1;
        s_x = -7; s_y = -8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_full_ready", s_ready, 0);
            check_val("bp_hold_a_x", m_x, 3);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_b_x", m_x, 6);
        check_val("bp_b_angle", m_angle, Q);
        check_val("bp_ready_again", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_val("bp_c_x", m_x, 8);
        check_val("bp_c_angle", m_angle, -Q);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("bp_drained", m_valid, 0);
        @(posedge clk); #1;

        // Sustained streaming: one word per cycle.
        sent = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_x = rand_coord(); s_y = rand_coord();
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_val("stream_accepts", sent, 20);
        @(negedge clk);
        check_val("stream_last_valid", m_valid, 1);
        @(posedge clk); #1;

        // Random traffic against the scoreboard.
        sent = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_x = rand_coord();
            s_y = rand_coord();
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cycles++;
        end
        check_val("random_sent", sent, 10000);
        s_valid = 1'b0;
        m_ready = 1'b1;
        waited = 0;
        while (sb_q.size() > 0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val("drain_empty", sb_q.size(), 0);

        // Reset while FULL discards both held words.
        m_ready = 1'b0;
        s_valid = 1'b1; s_x = 11; s_y = -12;
        @(posedge clk); #1;
        s_x = -13; s_y = 14;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_val("rst_pre_full_ready", s_ready, 0);
        check_val("rst_pre_full_valid", m_valid, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check_val("rst_async_valid", m_valid, 0);
        check_val("rst_async_ready", s_ready, 0);
        sb_q.delete();
        @(negedge clk);
        check_val("rst_hold_valid", m_valid, 0);
        @(posedge clk); #1;
        check_val("rst_edge_valid", m_valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_no_stale", m_valid, 0);
        end
        @(posedge clk); #1;
        apply_word("post_reset", 9, -2, 9, -2, 0, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
